// File: rtl/dcache_writeline_buffer_if.sv
// Avalon-MM burst write bus between the writeline buffer and memory.
//
// Handshake: a beat is transferred on a rising clk edge where
// avm_write = 1 and avm_waitrequest = 0. While avm_waitrequest = 1 the
// master holds avm_address, avm_writedata and avm_write stable.
//
// Signals:
//   avm_address     master->slave  burst start address (line aligned)
//   avm_write       master->slave  write beat valid
//   avm_writedata   master->slave  current beat data
//   avm_byteenable  master->slave  byte lanes (always all enabled)
//   avm_burstcount  master->slave  beats per burst (always 4)
//   avm_waitrequest slave->master  slave stall
interface dcache_writeline_buffer_if;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [2:0]  avm_burstcount;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_byteenable, avm_burstcount,
        output avm_waitrequest
    );
endinterface

// File: rtl/dcache_writeline_buffer.sv
// Data-cache writeline buffer: accepts dirty 128-bit lines from the cache
// (WBINVD sweeps and evictions) into a small FIFO and drains each line to
// memory as a 4-beat Avalon-MM burst write.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   writeline_do        write-back request, held by requester until done
//   writeline_done      request accepted this cycle (combinational)
//   writeline_address   line address, bits [3:0] ignored
//   writeline_line      line data, word0 = [31:0]
//   snoop_address       read-path probe address, bits [3:0] ignored
//   snoop_hit           a buffered (not yet popped) line matches the probe
//   drained             FIFO empty and no burst in flight
//   avm                 Avalon-MM burst write master (see interface)
//   dbg_state           FSM state: 0 = IDLE, 1 = BURST
//
// Request handshake: writeline_do is a level held until writeline_done is
// seen high in the same cycle; the line is captured on that clock edge.
module dcache_writeline_buffer #(
    parameter int DEPTH  = 2,
    parameter int AW_PTR = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             writeline_do,
    output logic                             writeline_done,
    input  logic [31:0]                      writeline_address,
    input  logic [127:0]                     writeline_line,
    input  logic [31:0]                      snoop_address,
    output logic                             snoop_hit,
    output logic                             drained,
    dcache_writeline_buffer_if.master        avm,
    output logic                             dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    localparam logic [AW_PTR:0] DEPTH_CNT = (AW_PTR + 1)'(DEPTH);

    state_e              state;
    state_e              state_nxt;
    logic [AW_PTR-1:0]   wr_ptr;
    logic [AW_PTR-1:0]   rd_ptr;
    logic [AW_PTR:0]     count;
    logic [1:0]          beat;
    logic [27:0]         entry_addr [DEPTH];
    logic [127:0]        entry_line [DEPTH];
    logic [DEPTH-1:0]    entry_valid;
    logic [127:0]        head_line;
    logic                full;
    logic                push;
    logic                pop;
    logic                unused_low_bits;

    assign unused_low_bits = ^{writeline_address[3:0], snoop_address[3:0]};

    // Fullness is taken from the registered count, so a pop in the same
    // cycle never frees a slot for a push until the following cycle.
    assign full           = (count == DEPTH_CNT);
    assign writeline_done = rst_n && writeline_do && !full;
    assign push           = writeline_done;
    assign pop            = (state == S_BURST) && !avm.avm_waitrequest && (beat == 2'd3);

    assign drained   = (count == '0) && (state == S_IDLE);
    assign dbg_state = (state == S_BURST);

    // Bus outputs come straight from registered head/beat state, so they are
    // inherently stable while the slave stalls.
    assign head_line          = entry_line[rd_ptr];
    assign avm.avm_address    = {entry_addr[rd_ptr], 4'd0};
    assign avm.avm_writedata  = head_line[{beat, 5'd0} +: 32];
    assign avm.avm_byteenable = 4'hF;
    assign avm.avm_burstcount = 3'd4;

    always_comb begin
        state_nxt     = state;
        avm.avm_write = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                avm.avm_write = 1'b1;
                if (pop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            beat        <= '0;
            entry_valid <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE) begin
                beat <= '0;
            end else if (!avm.avm_waitrequest) begin
                beat <= beat + 2'd1;   // wraps 3->0 exactly on the pop beat
            end

            // Pop and push never target the same slot: a pop needs count>0
            // and a push needs count<DEPTH, so the pointers differ.
            if (pop) begin
                rd_ptr              <= rd_ptr + AW_PTR'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= wr_ptr + AW_PTR'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end

            if (push && !pop) begin
                count <= count + (AW_PTR + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW_PTR + 1)'(1);
            end
        end
    end

    // Payload storage needs no reset: validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[wr_ptr] <= writeline_address[31:4];
            entry_line[wr_ptr] <= writeline_line;
        end
    end

    always_comb begin
        snoop_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == snoop_address[31:4])) begin
                snoop_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_writeline_buffer.sv
// Directed bench for dcache_writeline_buffer (DEPTH = 2).
// Inputs change on the falling edge; outputs are sampled 1 ns later, and
// the bus monitor samples 2 ns after the falling edge, away from posedge.
module tb_dcache_writeline_buffer;

    logic         clk;
    logic         rst_n;
    logic         wl_do;
    logic         wl_done;
    logic [31:0]  wl_addr;
    logic [127:0] wl_line;
    logic [31:0]  snoop_addr;
    logic         snoop_hit;
    logic         drained;
    logic         dbg_state;

    int n_checks;
    int n_pass;
    int beats_seen;
    int beats_mark;

    logic [63:0] exp_q[$];

    dcache_writeline_buffer_if avm_if ();

    dcache_writeline_buffer #(
        .DEPTH  (2),
        .AW_PTR (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .writeline_do      (wl_do),
        .writeline_done    (wl_done),
        .writeline_address (wl_addr),
        .writeline_line    (wl_line),
        .snoop_address     (snoop_addr),
        .snoop_hit         (snoop_hit),
        .drained           (drained),
        .avm               (avm_if),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [31:0] a, input logic [127:0] l);
        wl_do   = 1'b1;
        wl_addr = a;
        wl_line = l;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [127:0] l);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({a[31:4], 4'h0, l[k*32 +: 32]});
        end
    endtask

    // Holds the request until accepted or the budget runs out.
    task automatic push_hold(input string tag, input logic [31:0] a, input logic [127:0] l);
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            drive_req(a, l);
            #1;
            if (wl_done) break;
        end
        check(tag, wl_done, 1'b1);
        if (wl_done) push_exp(a, l);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        for (int w = 0; w < budget; w++) begin
            @(negedge clk);
            wl_do = 1'b0;
            #1;
            if (drained) break;
        end
        check(tag, drained, 1'b1);
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    always @(negedge clk) begin
        #2;
        if (rst_n && avm_if.avm_write && !avm_if.avm_waitrequest) begin
            beats_seen++;
            check("beat_expected", exp_q.size() != 0, 1'b1);
            check("beat_be_bc", {avm_if.avm_byteenable, avm_if.avm_burstcount}, {4'hF, 3'd4});
            if (exp_q.size() != 0) begin
                check("beat_addr_data", {avm_if.avm_address, avm_if.avm_writedata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed tests ----------------
    logic [31:0] t1_words [4];

    initial begin
        n_checks = 0;
        n_pass = 0;
        beats_seen = 0;
        rst_n = 1'b0;
        wl_do = 1'b0;
        wl_addr = '0;
        wl_line = '0;
        snoop_addr = '0;
        avm_if.avm_waitrequest = 1'b0;
        t1_words[0] = 32'h11111111;
        t1_words[1] = 32'h22222222;
        t1_words[2] = 32'h33333333;
        t1_words[3] = 32'h44444444;

        // Reset state, including a request presented during reset.
        repeat (2) @(negedge clk);
        wl_do = 1'b1;
        #1;
        check("rst_write", avm_if.avm_write, 1'b0);
        check("rst_drained", drained, 1'b1);
        check("rst_done", wl_done, 1'b0);
        check("rst_snoop", snoop_hit, 1'b0);
        check("rst_state", dbg_state, 1'b0);
        @(negedge clk);
        wl_do = 1'b0;
        rst_n = 1'b1;

        // Test 1: single line, no stall.
        @(negedge clk);
        drive_req(32'h0001_2340, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        #1;
        check("t1_done", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        @(negedge clk);
        wl_do = 1'b0;
        #1;
        check("t1_idle_write", avm_if.avm_write, 1'b0);
        check("t1_idle_drained", drained, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("t1_write", avm_if.avm_write, 1'b1);
            check("t1_addr", avm_if.avm_address, 32'h0001_2340);
            check("t1_data", avm_if.avm_writedata, t1_words[k]);
            check("t1_state", dbg_state, 1'b1);
        end
        @(negedge clk);
        #1;
        check("t1_end_write", avm_if.avm_write, 1'b0);
        check("t1_end_drained", drained, 1'b1);

        // Test 2: waitrequest for 3 cycles on beat 1.
        beats_mark = beats_seen;
        @(negedge clk);
        drive_req(32'h0001_2340, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        #1;
        check("t2_done", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        @(negedge clk);
        wl_do = 1'b0;
        @(negedge clk);
        #1;
        check("t2_beat0", avm_if.avm_writedata, 32'h11111111);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            avm_if.avm_waitrequest = (c < 3);
            #1;
            check("t2_hold_write", avm_if.avm_write, 1'b1);
            check("t2_hold_addr", avm_if.avm_address, 32'h0001_2340);
            check("t2_hold_data", avm_if.avm_writedata, 32'h22222222);
        end
        @(negedge clk);
        #1;
        check("t2_beat2", avm_if.avm_writedata, 32'h33333333);
        @(negedge clk);
        #1;
        check("t2_beat3", avm_if.avm_writedata, 32'h44444444);
        @(negedge clk);
        #1;
        check("t2_drained", drained, 1'b1);
        check("t2_beat_count", beats_seen - beats_mark, 4);

        // Test 3: full FIFO with slave stalled.
        avm_if.avm_waitrequest = 1'b1;
        @(negedge clk);
        drive_req(32'h0002_0000, {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});
        #1;
        check("t3_done0", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        @(negedge clk);
        drive_req(32'h0002_0010, {32'hA1000003, 32'hA1000002, 32'hA1000001, 32'hA1000000});
        #1;
        check("t3_done1", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_req(32'h0002_0020, {32'hA2000003, 32'hA2000002, 32'hA2000001, 32'hA2000000});
            #1;
            check("t3_full_stall", wl_done, 1'b0);
            check("t3_burst_stalled", avm_if.avm_write, 1'b1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            avm_if.avm_waitrequest = 1'b0;
            #1;
            check("t3_full_drain", wl_done, 1'b0);
        end
        check("t3_pop_beat", avm_if.avm_writedata, 32'hA0000003);
        @(negedge clk);
        #1;
        check("t3_done2", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        wait_drained("t3_drained", 60);

        // Test 4: snoop visibility across the entry lifetime.
        avm_if.avm_waitrequest = 1'b1;
        @(negedge clk);
        drive_req(32'h0000_A5A0, {32'h5A000003, 32'h5A000002, 32'h5A000001, 32'h5A000000});
        snoop_addr = 32'h0000_A5AC;
        #1;
        check("t4_done", wl_done, 1'b1);
        check("t4_snoop_push_cycle", snoop_hit, 1'b0);
        push_exp(wl_addr, wl_line);
        @(negedge clk);
        wl_do = 1'b0;
        #1;
        check("t4_snoop_hit", snoop_hit, 1'b1);
        snoop_addr = 32'h0000_A5B0;
        #1;
        check("t4_snoop_miss", snoop_hit, 1'b0);
        snoop_addr = 32'h0000_A5AC;
        @(negedge clk);
        #1;
        check("t4_snoop_in_burst", snoop_hit, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            avm_if.avm_waitrequest = 1'b0;
        end
        #1;
        check("t4_snoop_pop_cycle", snoop_hit, 1'b1);
        @(negedge clk);
        #1;
        check("t4_snoop_after_pop", snoop_hit, 1'b0);
        check("t4_drained", drained, 1'b1);

        // Test 5: reset during beat 2.
        @(negedge clk);
        drive_req(32'h0000_BEE0, {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000});
        #1;
        check("t5_done", wl_done, 1'b1);
        push_exp(wl_addr, wl_line);
        @(negedge clk);
        wl_do = 1'b0;
        snoop_addr = 32'h0000_BEE0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_write", avm_if.avm_write, 1'b0);
        check("t5_rst_drained", drained, 1'b1);
        check("t5_rst_snoop", snoop_hit, 1'b0);
        check("t5_abandoned_beats", exp_q.size(), 2);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beats_mark = beats_seen;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            check("t5_no_write", avm_if.avm_write, 1'b0);
        end
        check("t5_no_beats", beats_seen - beats_mark, 0);

        // Test 6: five lines through a two-entry FIFO (pointer wrap).
        // Low address bits are set on purpose; the bus must show them cleared.
        for (int i = 0; i < 5; i++) begin
            push_hold("t6_accept", 32'h0010_0005 + 32'(i) * 32'h40,
                      {32'hC0DE0003 | (32'(i) << 8), 32'hC0DE0002 | (32'(i) << 8),
                       32'hC0DE0001 | (32'(i) << 8), 32'hC0DE0000 | (32'(i) << 8)});
        end
        wait_drained("t6_drained", 100);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_writeline_buffer.md
Name: dcache_writeline_buffer

Overview:
- Downstream consumer of the data-cache writeline request (dirty-line write-back from WBINVD sweeps and evictions).
- Accepts 128-bit lines into a small FIFO, acknowledging each with a done pulse.
- Drains the FIFO to memory as 4-beat Avalon-MM burst writes.
- Provides an address snoop so the read path can detect a line still pending write-back, plus a drained flag for WBINVD completion.

Parameters:
- DEPTH, 2, number of buffered lines; power of two, minimum 2.
- AW_PTR, 1, log2(DEPTH), pointer width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- writeline_do  input  1  write-back request, held until done
- writeline_done  output  1  request accepted this cycle
- writeline_address  input  32  line address; bits [3:0] ignored
- writeline_line  input  128  line data; word0 = [31:0]
- snoop_address  input  32  address probed by the read path; bits [3:0] ignored
- snoop_hit  output  1  a valid buffered entry matches snoop_address[31:4]
- drained  output  1  FIFO empty and no burst in flight
- avm_address  output  32  burst start address, {line[31:4],4'd0}
- avm_write  output  1  write beat valid
- avm_writedata  output  32  current beat data
- avm_byteenable  output  4  always 4'hF
- avm_burstcount  output  3  always 3'd4
- avm_waitrequest  input  1  slave stall

Behaviour:
- Reset (async, any time, including mid-burst):
  - FIFO pointers and count = 0; all entries invalid; state = IDLE; beat counter = 0.
  - avm_write = 0, writeline_done = 0, snoop_hit = 0, drained = 1.
  - A burst interrupted by reset is abandoned, not resumed.
- Accept:
  - writeline_done = writeline_do && (count != DEPTH), combinational, same cycle.
  - On done, store {address[31:4], line} at the write pointer; increment the pointer with wrap at DEPTH.
  - One accept per cycle at most.
- Full:
  - While count == DEPTH, done stays 0 and the requester holds its request.
  - Fullness is evaluated before a same-cycle pop: a pop in that cycle does not enable a push; the push completes the next cycle.
- Count update:
  - Push-only: +1. Pop-only: −1. Push and pop in the same cycle: unchanged.
- States:
  - IDLE: avm_write = 0. If count != 0, go to BURST with beat = 0; the burst starts the next cycle.
  - BURST: avm_write = 1; avm_address = head entry {addr,4'd0}, constant for all four beats; avm_writedata = head line word[beat].
    - On !avm_waitrequest, beat increments.
    - On beat == 3 and !avm_waitrequest: pop the head (read pointer +1 with wrap, entry invalidated), beat = 0, go to IDLE.
    - Minimum one IDLE cycle between bursts.
  - Beat index is 2 bits and wraps 3→0 only on pop.
- Data stability: avm_address, avm_writedata and avm_write are held stable while avm_waitrequest = 1.
- Latency: a line accepted at cycle T has beat0 on the bus at T+2 at the earliest (T+1 IDLE sees count, T+2 BURST).
- snoop_hit:
  - Combinational OR over all valid entries of (entry_addr == snoop_address[31:4]).
  - The head entry counts as valid until its pop cycle ends, including during its burst.
  - A line pushed in cycle T is visible to snoop from T+1.
- drained = (count == 0) && (state == IDLE), registered-state derived, no combinational path from writeline_do.
- Duplicate addresses may coexist in the FIFO; they are written in order, and the later entry wins in memory.

Test Plan:
- Single line: push addr 0x0001_2340, line words {0x11111111,0x22222222,0x33333333,0x44444444}, waitrequest = 0 → done pulse at T; beats at T+2..T+5 with avm_address 0x0001_2340 and data 0x11111111 first; drained = 1 at T+6.
- Backpressure: the same push with waitrequest = 1 for 3 cycles on beat 1 → beat-1 data 0x22222222 and address held for 4 cycles; exactly 4 accepted beats in total.
- Full: push 3 lines back-to-back with waitrequest = 1 → done for the first two only; the third request is held; after the first burst pops, the third is accepted the following cycle.
- Snoop: buffer line 0x0000_A5A0, probe 0x0000_A5AC → hit = 1; probe 0x0000_A5B0 → hit = 0; after the final beat pops, probe 0x0000_A5AC → hit = 0.
- Reset mid-burst: assert rst_n = 0 during beat 2 → avm_write = 0 immediately, drained = 1; after release with no new pushes, no further writes occur.
- Wrap: push/drain 5 lines sequentially with DEPTH = 2 → addresses appear on the bus in push order; pointers wrap correctly; count returns to 0.
